// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: round-robin AR grant, in-order owner FIFO for R routing.
// Define RD_ARB_FIXED_PRIORITY_EN to make master 0 win every tie instead of round-robin.
module axi_rd_arbiter #(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_OUTSTANDING = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  // master 0 AR
  input  logic                       s0_ar_valid,
  output logic                       s0_ar_ready,
  input  logic [ADDR_BITS-1:0]       s0_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s0_ar_len,
  input  logic [TID_WIDTH-1:0]       s0_ar_id,
  // master 1 AR
  input  logic                       s1_ar_valid,
  output logic                       s1_ar_ready,
  input  logic [ADDR_BITS-1:0]       s1_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s1_ar_len,
  input  logic [TID_WIDTH-1:0]       s1_ar_id,
  // DRAM AR
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  // DRAM R
  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  input  logic [TID_WIDTH-1:0]       m_r_id,
  input  logic                       m_r_last,
  // master 0 R
  output logic                       s0_r_valid,
  input  logic                       s0_r_ready,
  output logic [DATA_WIDTH-1:0]      s0_r_data,
  output logic [TID_WIDTH-1:0]       s0_r_id,
  output logic                       s0_r_last,
  // master 1 R
  output logic                       s1_r_valid,
  input  logic                       s1_r_ready,
  output logic [DATA_WIDTH-1:0]      s1_r_data,
  output logic [TID_WIDTH-1:0]       s1_r_id,
  output logic                       s1_r_last,
  // status
  output logic [LOG_OUTSTANDING:0]   outstanding,
  output logic                       err_orphan_r
);

  localparam int D = 1 << LOG_OUTSTANDING;
  localparam logic [LOG_OUTSTANDING:0] FULL_CNT = (LOG_OUTSTANDING+1)'(D);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  logic                       r_state;
  logic                       r_last_grant;
  logic                       r_owner;
  logic [ADDR_BITS-1:0]       r_m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] r_m_ar_len;
  logic [TID_WIDTH-1:0]       r_m_ar_id;
  logic [D-1:0]               r_fifo;
  logic [LOG_OUTSTANDING-1:0] r_wptr;
  logic [LOG_OUTSTANDING-1:0] r_rptr;
  logic [LOG_OUTSTANDING:0]   r_count;
  logic                       r_err;

  logic w_tie_win;
  logic w_win;
  logic w_grant;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_head;

`ifdef RD_ARB_FIXED_PRIORITY_EN
  assign w_tie_win = 1'b0;
`else
  assign w_tie_win = ~r_last_grant;
`endif

  // Winner index: 1 means master 1. A lone requester always wins.
  assign w_win   = (s0_ar_valid & s1_ar_valid) ? w_tie_win : s1_ar_valid;
  assign w_grant = (r_state == ST_IDLE) && (r_count < FULL_CNT)
                   && (s0_ar_valid || s1_ar_valid);

  assign s0_ar_ready = w_grant & ~w_win;
  assign s1_ar_ready = w_grant &  w_win;

  assign m_ar_valid = (r_state == ST_ISSUE);
  assign m_ar_addr  = r_m_ar_addr;
  assign m_ar_len   = r_m_ar_len;
  assign m_ar_id    = r_m_ar_id;

  assign w_push  = (r_state == ST_ISSUE) & m_ar_ready;
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // R routing follows the oldest outstanding burst; DRAM returns bursts in issue order.
  assign s0_r_valid = ~w_empty & ~w_head & m_r_valid;
  assign s1_r_valid = ~w_empty &  w_head & m_r_valid;
  assign m_r_ready  = ~w_empty & (w_head ? s1_r_ready : s0_r_ready);
  assign w_pop      = m_r_valid & m_r_ready & m_r_last;

  assign s0_r_data = m_r_data;
  assign s0_r_id   = m_r_id;
  assign s0_r_last = m_r_last;
  assign s1_r_data = m_r_data;
  assign s1_r_id   = m_r_id;
  assign s1_r_last = m_r_last;

  assign outstanding  = r_count;
  assign err_orphan_r = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_m_ar_addr  <= '0;
      r_m_ar_len   <= '0;
      r_m_ar_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_grant) begin
          r_state      <= ST_ISSUE;
          r_last_grant <= w_win;
          r_owner      <= w_win;
          r_m_ar_addr  <= w_win ? s1_ar_addr : s0_ar_addr;
          r_m_ar_len   <= w_win ? s1_ar_len  : s0_ar_len;
          r_m_ar_id    <= w_win ? s1_ar_id   : s0_ar_id;
        end
        ST_ISSUE: if (m_ar_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Owner-order FIFO; storage needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= r_owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (m_r_valid && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter (default round-robin build, LOG_OUTSTANDING = 3).
module tb_axi_rd_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
  logic [15:0] s0_ar_addr, s1_ar_addr, m_ar_addr;
  logic [7:0]  s0_ar_len, s1_ar_len, m_ar_len;
  logic [7:0]  s0_ar_id, s1_ar_id, m_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_data, m_r_id;
  logic        s0_r_valid, s0_r_ready, s0_r_last, s1_r_valid, s1_r_ready, s1_r_last;
  logic [7:0]  s0_r_data, s0_r_id, s1_r_data, s1_r_id;
  logic [3:0]  outstanding;
  logic        err_orphan_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
    .s0_ar_len(s0_ar_len), .s0_ar_id(s0_ar_id),
    .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
    .s1_ar_len(s1_ar_len), .s1_ar_id(s1_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_id(m_r_id), .m_r_last(m_r_last),
    .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_data(s0_r_data),
    .s0_r_id(s0_r_id), .s0_r_last(s0_r_last),
    .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_data(s1_r_data),
    .s1_r_id(s1_r_id), .s1_r_last(s1_r_last),
    .outstanding(outstanding), .err_orphan_r(err_orphan_r)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    s0_ar_valid = 0; s0_ar_addr = 0; s0_ar_len = 0; s0_ar_id = 0;
    s1_ar_valid = 0; s1_ar_addr = 0; s1_ar_len = 0; s1_ar_id = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_id = 0; m_r_last = 0;
    s0_r_ready = 1; s1_r_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (m_ar_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_ar_valid got %b exp 0", m_ar_valid); end
    n_cmp++; if ({m_ar_addr, m_ar_len, m_ar_id} !== 32'h0) begin n_bad++; $display("FAIL rst_m_ar_fields got %h exp 0", {m_ar_addr, m_ar_len, m_ar_id}); end
    n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    n_cmp++; if (err_orphan_r !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", err_orphan_r); end
    n_cmp++; if ({s0_ar_ready, s1_ar_ready, s0_r_valid, s1_r_valid, m_r_ready} !== 5'b0) begin n_bad++;
      $display("FAIL rst_handshakes got %b exp 00000", {s0_ar_ready, s1_ar_ready, s0_r_valid, s1_r_valid, m_r_ready}); end
  endtask

  task automatic test_single();
    do_reset();
    s0_ar_valid = 1; s0_ar_addr = 16'h0EEF; s0_ar_len = 0; s0_ar_id = 8'd5; m_ar_ready = 1;
    #1;
    n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== 2'b10) begin n_bad++; $display("FAIL single_ar_ready got %b exp 10", {s0_ar_ready, s1_ar_ready}); end
    step(); s0_ar_valid = 0; #1;
    n_cmp++; if ({m_ar_valid, m_ar_addr, m_ar_len, m_ar_id} !== {1'b1, 16'h0EEF, 8'd0, 8'd5}) begin n_bad++;
      $display("FAIL single_m_ar got %h exp %h", {m_ar_valid, m_ar_addr, m_ar_len, m_ar_id}, {1'b1, 16'h0EEF, 8'd0, 8'd5}); end
    n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== 2'b00) begin n_bad++; $display("FAIL single_issue_ready got %b exp 00", {s0_ar_ready, s1_ar_ready}); end
    step();
    m_r_valid = 1; m_r_data = 8'hA5; m_r_id = 8'd5; m_r_last = 1; #1;
    n_cmp++; if ({s0_r_valid, s1_r_valid, m_r_ready, s0_r_last, s0_r_data, s0_r_id} !== {4'b1011, 8'hA5, 8'd5}) begin n_bad++;
      $display("FAIL single_r_route got %h exp %h", {s0_r_valid, s1_r_valid, m_r_ready, s0_r_last, s0_r_data, s0_r_id}, {4'b1011, 8'hA5, 8'd5}); end
    n_cmp++; if ({m_ar_valid, outstanding} !== {1'b0, 4'd1}) begin n_bad++; $display("FAIL single_after_push got %h exp 01", {m_ar_valid, outstanding}); end
    step(); m_r_valid = 0; m_r_last = 0; #1;
    n_cmp++; if ({outstanding, s1_r_valid} !== {4'd0, 1'b0}) begin n_bad++; $display("FAIL single_drain got %h exp 0", {outstanding, s1_r_valid}); end
  endtask

  task automatic test_tie_fairness();
    logic exp_m;
    do_reset();
    s0_ar_valid = 1; s0_ar_addr = 16'h0100; s0_ar_id = 8'd1;
    s1_ar_valid = 1; s1_ar_addr = 16'h0200; s1_ar_id = 8'd2; m_ar_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_m = i[0];
      #1;
      n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== {~exp_m, exp_m}) begin n_bad++;
        $display("FAIL tie_grant%0d got %b exp %b", i, {s0_ar_ready, s1_ar_ready}, {~exp_m, exp_m}); end
      step(); #1;
      n_cmp++; if ({m_ar_valid, m_ar_id, s0_ar_ready, s1_ar_ready} !== {1'b1, (exp_m ? 8'd2 : 8'd1), 2'b00}) begin n_bad++;
        $display("FAIL tie_issue%0d got %h exp %h", i, {m_ar_valid, m_ar_id, s0_ar_ready, s1_ar_ready}, {1'b1, (exp_m ? 8'd2 : 8'd1), 2'b00}); end
      step();
    end
    s0_ar_valid = 0; s1_ar_valid = 0; #1;
    n_cmp++; if (outstanding !== 4'd4) begin n_bad++; $display("FAIL tie_outstanding got %0d exp 4", outstanding); end
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 2; b++) begin
        exp_m = k[0];
        m_r_valid = 1; m_r_data = 8'(k * 16 + b); m_r_last = (b == 1); #1;
        n_cmp++; if ({s0_r_valid, s1_r_valid, m_r_ready} !== {~exp_m, exp_m, 1'b1}) begin n_bad++;
          $display("FAIL tie_r_route k%0d b%0d got %b exp %b", k, b, {s0_r_valid, s1_r_valid, m_r_ready}, {~exp_m, exp_m, 1'b1}); end
        step();
      end
    end
    m_r_valid = 0; m_r_last = 0; #1;
    n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("FAIL tie_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    s0_ar_valid = 1; s0_ar_addr = 16'h1000; s0_ar_id = 8'd3; s0_r_ready = 0; m_ar_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (s0_ar_ready !== 1'b1) begin n_bad++; $display("FAIL full_grant%0d got %b exp 1", i, s0_ar_ready); end
      step(); step();
    end
    #1;
    n_cmp++; if ({outstanding, s0_ar_ready} !== {4'd8, 1'b0}) begin n_bad++; $display("FAIL full_at8 got %h exp 10", {outstanding, s0_ar_ready}); end
    step(); #1;
    n_cmp++; if ({outstanding, s0_ar_ready, m_ar_valid} !== {4'd8, 2'b00}) begin n_bad++; $display("FAIL full_hold got %h exp 20", {outstanding, s0_ar_ready, m_ar_valid}); end
    m_r_valid = 1; m_r_last = 1; s0_r_ready = 1; #1;
    n_cmp++; if ({m_r_ready, s0_r_valid, s0_ar_ready} !== 3'b110) begin n_bad++; $display("FAIL full_release got %b exp 110", {m_r_ready, s0_r_valid, s0_ar_ready}); end
    step(); m_r_valid = 0; m_r_last = 0; #1;
    n_cmp++; if ({outstanding, s0_ar_ready} !== {4'd7, 1'b1}) begin n_bad++; $display("FAIL full_ninth_grant got %h exp 0f", {outstanding, s0_ar_ready}); end
    step(); s0_ar_valid = 0; #1;
    n_cmp++; if (m_ar_valid !== 1'b1) begin n_bad++; $display("FAIL full_ninth_issue got %b exp 1", m_ar_valid); end
    step(); #1;
    n_cmp++; if (outstanding !== 4'd8) begin n_bad++; $display("FAIL full_wrap got %0d exp 8", outstanding); end
  endtask

  task automatic test_backpressure();
    do_reset();
    s1_ar_valid = 1; s1_ar_addr = 16'h0300; s1_ar_len = 8'd3; s1_ar_id = 8'd7; m_ar_ready = 1;
    step(); s1_ar_valid = 0; step();
    m_r_valid = 1; m_r_id = 8'd7; m_r_data = 8'h40; m_r_last = 0; #1;
    n_cmp++; if ({s1_r_valid, s0_r_valid, m_r_ready, s1_r_data} !== {3'b101, 8'h40}) begin n_bad++;
      $display("FAIL bp_beat0 got %h exp 540", {s1_r_valid, s0_r_valid, m_r_ready, s1_r_data}); end
    step();
    m_r_data = 8'h41; s1_r_ready = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if ({s1_r_valid, m_r_ready, s1_r_data, outstanding} !== {2'b10, 8'h41, 4'd1}) begin n_bad++;
        $display("FAIL bp_stall%0d got %h exp %h", c, {s1_r_valid, m_r_ready, s1_r_data, outstanding}, {2'b10, 8'h41, 4'd1}); end
      step();
    end
    s1_r_ready = 1;
    for (int b = 1; b < 4; b++) begin
      m_r_data = 8'(8'h40 + b); m_r_last = (b == 3); #1;
      n_cmp++; if ({s1_r_valid, m_r_ready, s1_r_last, s1_r_data} !== {2'b11, (b == 3), 8'(8'h40 + b)}) begin n_bad++;
        $display("FAIL bp_beat%0d got %h exp %h", b, {s1_r_valid, m_r_ready, s1_r_last, s1_r_data}, {2'b11, (b == 3), 8'(8'h40 + b)}); end
      step();
    end
    m_r_valid = 0; m_r_last = 0; #1;
    n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("FAIL bp_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_orphan();
    do_reset();
    m_r_valid = 1; m_r_last = 1; #1;
    n_cmp++; if ({s0_r_valid, s1_r_valid, m_r_ready, err_orphan_r} !== 4'b0) begin n_bad++;
      $display("FAIL orphan_same_cycle got %b exp 0000", {s0_r_valid, s1_r_valid, m_r_ready, err_orphan_r}); end
    step(); m_r_valid = 0; m_r_last = 0; #1;
    n_cmp++; if ({err_orphan_r, outstanding} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL orphan_set got %h exp 10", {err_orphan_r, outstanding}); end
    step(); step(); step(); #1;
    n_cmp++; if (err_orphan_r !== 1'b1) begin n_bad++; $display("FAIL orphan_sticky got %b exp 1", err_orphan_r); end
    rst = 1; step(); rst = 0; #1;
    n_cmp++; if (err_orphan_r !== 1'b0) begin n_bad++; $display("FAIL orphan_clear got %b exp 0", err_orphan_r); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    s0_ar_valid = 1; s0_ar_addr = 16'h0ABC; s0_ar_id = 8'd4; m_ar_ready = 1;
    for (int i = 0; i < 3; i++) begin step(); step(); end
    m_ar_ready = 0; step(); s0_ar_valid = 0; #1;
    n_cmp++; if ({m_ar_valid, outstanding} !== {1'b1, 4'd3}) begin n_bad++; $display("FAIL mrst_pre got %h exp 13", {m_ar_valid, outstanding}); end
    rst = 1; step(); rst = 0; #1;
    n_cmp++; if ({m_ar_valid, outstanding, m_ar_addr} !== {1'b0, 4'd0, 16'h0}) begin n_bad++;
      $display("FAIL mrst_post got %h exp 0", {m_ar_valid, outstanding, m_ar_addr}); end
    s1_ar_valid = 1; s1_ar_addr = 16'h0555; s1_ar_id = 8'd9; m_ar_ready = 1; #1;
    n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== 2'b01) begin n_bad++; $display("FAIL mrst_regrant got %b exp 01", {s0_ar_ready, s1_ar_ready}); end
    step(); s1_ar_valid = 0; #1;
    n_cmp++; if ({m_ar_valid, m_ar_addr, m_ar_id} !== {1'b1, 16'h0555, 8'd9}) begin n_bad++;
      $display("FAIL mrst_issue got %h exp %h", {m_ar_valid, m_ar_addr, m_ar_id}, {1'b1, 16'h0555, 8'd9}); end
    step(); #1;
    n_cmp++; if (outstanding !== 4'd1) begin n_bad++; $display("FAIL mrst_push got %0d exp 1", outstanding); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_fairness();
    test_full_fifo();
    test_backpressure();
    test_orphan();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
